colordetect_accel_hls_deadlock_report_ctrl: RTL and testbench
=============================================================

Name: colordetect_accel_hls_deadlock_report_ctrl

Overview:
Top-level collector downstream of the per-process deadlock detect units in the colordetect accelerator dataflow region. Takes every unit's dl_detect_out, confirms a persistent detection and picks one originating process. It then drives that unit's origin input to launch the token trace, and pulses token_clear when the trace closes. It latches a sticky deadlock report (flag, process id, cycle count) for the host/debug path until acknowledged.

Parameters:
PROC_NUM, 4, number of dataflow processes / detect units
ID_W, 2, width of process index; must satisfy 2^ID_W >= PROC_NUM
CONFIRM_CYCLES, 8, consecutive cycles a detection must hold before being accepted (>=1)
TRACE_TIMEOUT, 64, max cycles to wait for token return before abandoning trace (>=2)
CNT_W, 16, width of deadlock event counter

Ports:
reset  input  1  asynchronous, active-low reset
clock  input  1  clock, all state on rising edge
dl_detect_vec  input  PROC_NUM  bit i = dl_detect_out of detect unit i
report_ack  input  1  host acknowledge; releases sticky report
origin_vec  output  PROC_NUM  one-hot origin strobe to detect units (bit i -> unit i origin)
token_clear  output  1  broadcast to all units' token_clear
deadlock_flag  output  1  sticky: confirmed deadlock
deadlock_proc_id  output  ID_W  index of originating process
trace_done  output  1  1 = token returned (full cycle traced), 0 = trace timed out
deadlock_cnt  output  CNT_W  number of confirmed deadlocks since reset, saturating

Behaviour:
- Reset (async, reset=0): state IDLE; all outputs 0; internal counters 0. Reset mid-trace abandons the trace immediately, with no token_clear pulse.
- Selection: sel = lowest index i with dl_detect_vec[i]=1 (fixed priority, bit 0 highest).
- IDLE: if |dl_detect_vec, latch cand=sel, conf_cnt=1, go CONFIRM. If CONFIRM_CYCLES==1, go directly to ORIGIN.
- CONFIRM: each cycle dl_detect_vec[cand]=1 -> conf_cnt++. If dl_detect_vec[cand]=0, go IDLE (conf_cnt=0, no report). Reaching conf_cnt==CONFIRM_CYCLES -> ORIGIN. A change in the set of other bits is ignored.
- ORIGIN: one cycle. origin_vec = 1<<cand (registered output, high exactly this cycle); tmo_cnt=0. Next TRACE.
- TRACE: tmo_cnt++ per cycle.
  - If dl_detect_vec[cand]=1 in any cycle after ORIGIN: token returned. token_clear=1 combinationally in that same cycle (same cycle as dl_detect_out per unit contract), then REPORT with trace_done=1.
  - If tmo_cnt reaches TRACE_TIMEOUT: token_clear=1 for that cycle, then REPORT with trace_done=0.
- REPORT entry (1st cycle): deadlock_flag=1, deadlock_proc_id=cand, deadlock_cnt++ (saturates at all-ones, no wrap).
  - Holds until report_ack=1, then IDLE; flag/id/trace_done cleared on that edge.
  - dl_detect_vec is ignored in REPORT.
  - report_ack outside REPORT has no effect.
  - Ack and new detection in the same cycle: ack wins; detection is re-sampled from IDLE next cycle.
- origin_vec is always zero or one-hot. token_clear is never high outside TRACE.
- Latency from first detect to origin strobe = CONFIRM_CYCLES cycles.

Optional Feature:
DEADLOCK_TIMESTAMP_EN:
- Defined: adds output dl_timestamp [31:0] and a free-running 32-bit cycle counter (wraps, reset 0). The counter value is captured at REPORT entry and held until ack, then cleared to 0.
- Undefined: no counter, no port; all other behaviour identical.

Test Plan:
- Reset, dl_detect_vec=0 for 20 cycles -> all outputs 0, origin_vec never set.
- dl_detect_vec=4'b0100 held; unit returns bit2 three cycles after origin -> origin_vec=4'b0100 for 1 cycle at cycle 8; token_clear 1 cycle coincident with return; deadlock_flag=1, proc_id=2, trace_done=1, cnt=1.
- dl_detect_vec=4'b0110 held -> cand=1 (priority); origin_vec=4'b0010.
- bit0 high for 5 cycles then low (CONFIRM_CYCLES=8) -> back to IDLE; flag stays 0, cnt 0.
- Confirm on bit3, no return -> token_clear pulse at TRACE cycle 64; flag=1, trace_done=0; report_ack -> flag/id clear next edge, cnt remains 1.
- Assert reset during TRACE -> outputs 0 asynchronously, no token_clear; post-reset IDLE; with DEADLOCK_TIMESTAMP_EN, dl_timestamp=0 and a later report captures the correct cycle count.

Source files
------------

// File: rtl/colordetect_accel_hls_deadlock_report_ctrl_if.sv
// Host/detect-unit side signal bundle for the deadlock report controller.
// Carries dl_timestamp only when DEADLOCK_TIMESTAMP_EN is defined.
interface colordetect_accel_hls_deadlock_report_ctrl_if #(
  parameter int PROC_NUM = 4,
  parameter int ID_W     = 2,
  parameter int CNT_W    = 16
);
  logic [PROC_NUM-1:0] dl_detect_vec;
  logic                report_ack;
  logic [PROC_NUM-1:0] origin_vec;
  logic                token_clear;
  logic                deadlock_flag;
  logic [ID_W-1:0]     deadlock_proc_id;
  logic                trace_done;
  logic [CNT_W-1:0]    deadlock_cnt;
`ifdef DEADLOCK_TIMESTAMP_EN
  logic [31:0]         dl_timestamp;

  modport slave (
    input  dl_detect_vec, report_ack,
    output origin_vec, token_clear, deadlock_flag, deadlock_proc_id,
           trace_done, deadlock_cnt, dl_timestamp
  );

  modport master (
    output dl_detect_vec, report_ack,
    input  origin_vec, token_clear, deadlock_flag, deadlock_proc_id,
           trace_done, deadlock_cnt, dl_timestamp
  );
`else
  modport slave (
    input  dl_detect_vec, report_ack,
    output origin_vec, token_clear, deadlock_flag, deadlock_proc_id,
           trace_done, deadlock_cnt
  );

  modport master (
    output dl_detect_vec, report_ack,
    input  origin_vec, token_clear, deadlock_flag, deadlock_proc_id,
           trace_done, deadlock_cnt
  );
`endif
endinterface

// File: rtl/colordetect_accel_hls_deadlock_report_ctrl.sv
// Deadlock report collector: confirms a detection, launches the token trace from
// one origin unit and latches a sticky report. Optional macro: DEADLOCK_TIMESTAMP_EN.
module colordetect_accel_hls_deadlock_report_ctrl #(
  parameter int PROC_NUM       = 4,
  parameter int ID_W           = 2,
  parameter int CONFIRM_CYCLES = 8,
  parameter int TRACE_TIMEOUT  = 64,
  parameter int CNT_W          = 16
) (
  input logic reset,
  input logic clock,
  colordetect_accel_hls_deadlock_report_ctrl_if.slave bus
);

  localparam int CONF_W = (CONFIRM_CYCLES > 1) ? $clog2(CONFIRM_CYCLES + 1) : 1;
  localparam int TMO_W  = $clog2(TRACE_TIMEOUT + 1);
  localparam logic [CONF_W-1:0] CONF_LAST = CONF_W'(CONFIRM_CYCLES - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TRACE_TIMEOUT);

  typedef enum logic [2:0] {
    IDLE,
    CONFIRM,
    ORIGIN,
    TRACE,
    REPORT
  } state_t;

  state_t              state, state_nxt;
  logic [ID_W-1:0]     cand, cand_nxt;
  logic [CONF_W-1:0]   conf_cnt, conf_nxt;
  logic [TMO_W-1:0]    tmo_cnt, tmo_nxt;
  logic [PROC_NUM-1:0] origin_q, origin_nxt;
  logic                flag_q, flag_nxt;
  logic [ID_W-1:0]     id_q, id_nxt;
  logic                done_q, done_nxt;
  logic [CNT_W-1:0]    cnt_q, cnt_nxt;
  logic                token_clear;
  logic                report_enter;
  logic                report_leave;

  logic [ID_W-1:0]     sel;
  logic                any_detect;
  logic                cand_hit;

  // Fixed priority: scan from the top so the lowest set index wins.
  always_comb begin
    sel = '0;
    for (int unsigned i = PROC_NUM; i > 0; i--) begin
      if (bus.dl_detect_vec[i-1]) sel = ID_W'(i - 1);
    end
  end

  assign any_detect = |bus.dl_detect_vec;
  assign cand_hit   = bus.dl_detect_vec[cand];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    cand_nxt     = cand;
    conf_nxt     = conf_cnt;
    tmo_nxt      = tmo_cnt;
    origin_nxt   = '0;
    flag_nxt     = flag_q;
    id_nxt       = id_q;
    done_nxt     = done_q;
    cnt_nxt      = cnt_q;
    token_clear  = 1'b0;
    report_enter = 1'b0;
    report_leave = 1'b0;

    case (state)
      IDLE: begin
        if (any_detect) begin
          cand_nxt = sel;
          if (CONFIRM_CYCLES == 1) begin
            state_nxt       = ORIGIN;
            origin_nxt[sel] = 1'b1;
            tmo_nxt         = '0;
          end else begin
            state_nxt = CONFIRM;
            conf_nxt  = CONF_W'(1);
          end
        end
      end

      CONFIRM: begin
        if (!cand_hit) begin
          state_nxt = IDLE;
          conf_nxt  = '0;
        end else if (conf_cnt == CONF_LAST) begin
          state_nxt        = ORIGIN;
          conf_nxt         = '0;
          origin_nxt[cand] = 1'b1;
          tmo_nxt          = '0;
        end else begin
          conf_nxt = conf_cnt + 1'b1;
        end
      end

      ORIGIN: begin
        // tmo_cnt holds the 1-based index of the current TRACE cycle.
        state_nxt = TRACE;
        tmo_nxt   = tmo_cnt + 1'b1;
      end

      TRACE: begin
        tmo_nxt = tmo_cnt + 1'b1;
        if (cand_hit || (tmo_cnt == TMO_LAST)) begin
          token_clear  = 1'b1;
          report_enter = 1'b1;
          state_nxt    = REPORT;
          tmo_nxt      = '0;
          flag_nxt     = 1'b1;
          id_nxt       = cand;
          done_nxt     = cand_hit;
          if (cnt_q != '1) cnt_nxt = cnt_q + 1'b1;
        end
      end

      REPORT: begin
        if (bus.report_ack) begin
          report_leave = 1'b1;
          state_nxt    = IDLE;
          flag_nxt     = 1'b0;
          id_nxt       = '0;
          done_nxt     = 1'b0;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cand     <= '0;
      conf_cnt <= '0;
      tmo_cnt  <= '0;
      origin_q <= '0;
      flag_q   <= 1'b0;
      id_q     <= '0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      cand     <= cand_nxt;
      conf_cnt <= conf_nxt;
      tmo_cnt  <= tmo_nxt;
      origin_q <= origin_nxt;
      flag_q   <= flag_nxt;
      id_q     <= id_nxt;
      done_q   <= done_nxt;
      cnt_q    <= cnt_nxt;
    end
  end

  assign bus.origin_vec       = origin_q;
  assign bus.token_clear      = token_clear;
  assign bus.deadlock_flag    = flag_q;
  assign bus.deadlock_proc_id = id_q;
  assign bus.trace_done       = done_q;
  assign bus.deadlock_cnt     = cnt_q;

`ifdef DEADLOCK_TIMESTAMP_EN
  logic [31:0] cycle_ctr;
  logic [31:0] ts_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cycle_ctr <= '0;
      ts_q      <= '0;
    end else begin
      cycle_ctr <= cycle_ctr + 1'b1;
      if (report_enter)      ts_q <= cycle_ctr;
      else if (report_leave) ts_q <= '0;
    end
  end

  assign bus.dl_timestamp = ts_q;
`else
  logic unused_ts;
  assign unused_ts = report_enter ^ report_leave;
`endif

endmodule

// File: tb/tb_colordetect_accel_hls_deadlock_report_ctrl.sv
// Directed bench for the deadlock report controller (default parameters).
module tb_colordetect_accel_hls_deadlock_report_ctrl;

  logic clock;
  logic reset;
  int   total;
  int   bad;

  colordetect_accel_hls_deadlock_report_ctrl_if #(
    .PROC_NUM (4),
    .ID_W     (2),
    .CNT_W    (16)
  ) bus ();

  colordetect_accel_hls_deadlock_report_ctrl #(
    .PROC_NUM       (4),
    .ID_W           (2),
    .CONFIRM_CYCLES (8),
    .TRACE_TIMEOUT  (64),
    .CNT_W          (16)
  ) dut (
    .reset (reset),
    .clock (clock),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_report(input string tag, input logic flag, input logic [1:0] id,
                            input logic done, input logic [15:0] cnt);
    chk({tag, "_flag"}, 32'(bus.deadlock_flag), 32'(flag));
    chk({tag, "_id"},   32'(bus.deadlock_proc_id), 32'(id));
    chk({tag, "_done"}, 32'(bus.trace_done), 32'(done));
    chk({tag, "_cnt"},  32'(bus.deadlock_cnt), 32'(cnt));
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    bus.dl_detect_vec = 4'b0000;
    bus.report_ack    = 1'b0;

    // Reset state
    repeat (2) tick();
    chk("rst_origin", 32'(bus.origin_vec), 32'h0);
    chk("rst_tclr", 32'(bus.token_clear), 32'h0);
    chk_report("rst", 1'b0, 2'd0, 1'b0, 16'd0);
    reset = 1'b1;

    // Quiet for 20 cycles
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("quiet_origin", 32'(bus.origin_vec), 32'h0);
    end
    chk_report("quiet", 1'b0, 2'd0, 1'b0, 16'd0);

    // Single detect on bit2, token back three cycles after origin
    bus.dl_detect_vec = 4'b0100;
    for (int i = 0; i < 8; i++) begin
      chk("p2_conf_origin", 32'(bus.origin_vec), 32'h0);
      tick();
    end
    chk("p2_origin", 32'(bus.origin_vec), 32'h4);
    chk("p2_origin_tclr", 32'(bus.token_clear), 32'h0);
    bus.dl_detect_vec = 4'b0000;
    tick();
    chk("p2_trace_origin", 32'(bus.origin_vec), 32'h0);
    chk("p2_trace_tclr", 32'(bus.token_clear), 32'h0);
    tick();
    tick();
    bus.dl_detect_vec = 4'b0100;
    #1;
    chk("p2_return_tclr", 32'(bus.token_clear), 32'h1);
    tick();
    chk("p2_rep_tclr", 32'(bus.token_clear), 32'h0);
    chk_report("p2_rep", 1'b1, 2'd2, 1'b1, 16'd1);
    tick();
    chk_report("p2_hold", 1'b1, 2'd2, 1'b1, 16'd1);
    bus.report_ack = 1'b1;
    tick();
    chk_report("p2_ack", 1'b0, 2'd0, 1'b0, 16'd1);
    bus.report_ack    = 1'b0;
    bus.dl_detect_vec = 4'b0000;
    repeat (3) tick();

    // Two bits set: priority picks bit1; a bit2 pulse in TRACE is not the token
    bus.dl_detect_vec = 4'b0110;
    repeat (8) tick();
    chk("p1_origin", 32'(bus.origin_vec), 32'h2);
    bus.dl_detect_vec = 4'b0000;
    tick();
    bus.dl_detect_vec = 4'b0100;
    #1;
    chk("p1_other_tclr", 32'(bus.token_clear), 32'h0);
    tick();
    bus.dl_detect_vec = 4'b0010;
    #1;
    chk("p1_return_tclr", 32'(bus.token_clear), 32'h1);
    tick();
    chk_report("p1_rep", 1'b1, 2'd1, 1'b1, 16'd2);
    bus.dl_detect_vec = 4'b0000;
    bus.report_ack    = 1'b1;
    tick();
    chk_report("p1_ack", 1'b0, 2'd0, 1'b0, 16'd2);
    bus.report_ack = 1'b0;
    tick();

    // Transient detect on bit0 for 5 cycles never confirms; stray ack ignored
    bus.dl_detect_vec = 4'b0001;
    repeat (5) tick();
    bus.dl_detect_vec = 4'b0000;
    bus.report_ack    = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("short_origin", 32'(bus.origin_vec), 32'h0);
    end
    bus.report_ack = 1'b0;
    chk_report("short", 1'b0, 2'd0, 1'b0, 16'd2);

    // Bit3 with no token return: timeout in the 64th TRACE cycle
    bus.dl_detect_vec = 4'b1000;
    repeat (8) tick();
    chk("p3_origin", 32'(bus.origin_vec), 32'h8);
    bus.dl_detect_vec = 4'b0000;
    tick();
    for (int k = 1; k < 64; k++) begin
      chk("p3_wait_tclr", 32'(bus.token_clear), 32'h0);
      tick();
    end
    chk("p3_tmo_tclr", 32'(bus.token_clear), 32'h1);
    tick();
    chk("p3_rep_tclr", 32'(bus.token_clear), 32'h0);
    chk_report("p3_rep", 1'b1, 2'd3, 1'b0, 16'd3);
    bus.report_ack = 1'b1;
    tick();
    chk_report("p3_ack", 1'b0, 2'd0, 1'b0, 16'd3);
    bus.report_ack = 1'b0;
    tick();

    // Reset while token_clear is high mid-trace
    bus.dl_detect_vec = 4'b0010;
    repeat (8) tick();
    chk("pr_origin", 32'(bus.origin_vec), 32'h2);
    bus.dl_detect_vec = 4'b0000;
    tick();
    bus.dl_detect_vec = 4'b0010;
    #1;
    chk("pr_tclr_before", 32'(bus.token_clear), 32'h1);
    reset = 1'b0;
    #1;
    chk("pr_tclr_async", 32'(bus.token_clear), 32'h0);
    chk("pr_origin_async", 32'(bus.origin_vec), 32'h0);
    chk_report("pr_async", 1'b0, 2'd0, 1'b0, 16'd0);
`ifdef DEADLOCK_TIMESTAMP_EN
    chk("pr_ts", bus.dl_timestamp, 32'h0);
`endif
    bus.dl_detect_vec = 4'b0000;
    tick();
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("post_rst_origin", 32'(bus.origin_vec), 32'h0);
      chk("post_rst_tclr", 32'(bus.token_clear), 32'h0);
    end
    chk_report("post_rst", 1'b0, 2'd0, 1'b0, 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
